// File: rtl/imm_gen_pipe.sv
// Registered RISC-V immediate generator with a valid/ready output stage.
// SKID=1 adds a second entry so in_ready comes straight from a flop.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8,
    parameter bit SKID  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [24:0]      in_instr,
    input  logic [2:0]       in_sel,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    localparam logic [2:0] FMT_I = 3'b000;
    localparam logic [2:0] FMT_S = 3'b001;
    localparam logic [2:0] FMT_B = 3'b010;
    localparam logic [2:0] FMT_U = 3'b011;
    localparam logic [2:0] FMT_J = 3'b100;
    localparam logic [2:0] FMT_Z = 3'b101;

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_gen_pipe: XLEN must be 32 or 64");
        end
    endgenerate

    logic [31:0]      imm32;
    logic             dec_illegal;
    logic [XLEN-1:0]  dec_imm;

    logic             skid_valid;
    logic [XLEN-1:0]  skid_imm;
    logic [TAG_W-1:0] skid_tag;
    logic             skid_illegal;

    logic             out_free;
    logic             accept;

    // in_instr[k-7] holds instruction bit k
    always_comb begin
        imm32       = '0;
        dec_illegal = 1'b0;
        case (in_sel)
            FMT_I:   imm32 = {{20{in_instr[24]}}, in_instr[24:13]};
            FMT_S:   imm32 = {{20{in_instr[24]}}, in_instr[24:18], in_instr[4:0]};
            FMT_B:   imm32 = {{19{in_instr[24]}}, in_instr[24], in_instr[0],
                              in_instr[23:18], in_instr[4:1], 1'b0};
            FMT_U:   imm32 = {in_instr[24:5], 12'b0};
            FMT_J:   imm32 = {{11{in_instr[24]}}, in_instr[24], in_instr[12:5],
                              in_instr[13], in_instr[23:14], 1'b0};
            FMT_Z:   imm32 = {27'b0, in_instr[12:8]};
            default: dec_illegal = 1'b1;
        endcase
    end

    assign dec_imm  = XLEN'({{32{imm32[31]}}, imm32});

    assign out_free = out_ready | ~out_valid;
    assign in_ready = ~rst & (SKID ? ~skid_valid : out_free);
    assign accept   = in_valid & in_ready;

    // The output register refills from skid first so ordering stays FIFO;
    // a stalled output can only accept into skid, which SKID=0 never enables.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_imm      <= '0;
            out_tag      <= '0;
            out_illegal  <= 1'b0;
            skid_valid   <= 1'b0;
            skid_imm     <= '0;
            skid_tag     <= '0;
            skid_illegal <= 1'b0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (out_free) begin
            if (skid_valid) begin
                out_valid   <= 1'b1;
                out_imm     <= skid_imm;
                out_tag     <= skid_tag;
                out_illegal <= skid_illegal;
                skid_valid  <= 1'b0;
            end else if (accept) begin
                out_valid   <= 1'b1;
                out_imm     <= dec_imm;
                out_tag     <= in_tag;
                out_illegal <= dec_illegal;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_valid   <= 1'b1;
            skid_imm     <= dec_imm;
            skid_tag     <= in_tag;
            skid_illegal <= dec_illegal;
        end
    end

endmodule
